// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin, packet-locking arbiter that feeds bytes from NREQ requesters
//   into a single 8N1 transmitter through a tx_en / tx_busy handshake.
//
// Ports
//   CLOCK        in   system clock, rising-edge active
//   RESET        in   asynchronous, active-high reset
//   req_valid    in   [NREQ]     per-requester byte available
//   req_data     in   [8*NREQ]   per-requester byte, requester i at [8i+7:8i]
//   req_last     in   [NREQ]     per-requester last byte of packet
//   req_ready    out  [NREQ]     per-requester accept (combinational)
//   tx_busy      in   transmitter busy
//   tx_en        out  one-cycle start strobe to the transmitter
//   tx_data      out  [8]        byte to transmit, held until next capture
//   grant        out  [NREQ]     one-hot packet owner, 0 when no owner
//   err_timeout  out  sticky: transmitter failed to go busy in time
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 3,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    input  logic                tx_busy,
    output logic                tx_en,
    output logic [7:0]          tx_data,
    output logic [NREQ-1:0]     grant,
    output logic                err_timeout
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   owner_q;
    logic               lock_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tx_en_q;
    logic [7:0]         tx_data_q;
    logic [NREQ-1:0]    grant_q;
    logic               err_q;

    logic               win_vld_d;
    logic [IDX_W-1:0]   win_idx_d;
    logic [NREQ-1:0]    win_oh_d;
    int unsigned        cand;

    // Index following the owner, wrapping at the last requester.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NREQ - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    // Winner selection: locked owner only, else first valid from rr_q upward.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand      = 0;
        if (lock_q) begin
            win_vld_d = req_valid[owner_q];
            win_idx_d = owner_q;
        end else begin
            for (int unsigned off = 0; off < NREQ; off++) begin
                cand = 32'(rr_q) + off;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                if (!win_vld_d && req_valid[IDX_W'(cand)]) begin
                    win_vld_d = 1'b1;
                    win_idx_d = IDX_W'(cand);
                end
            end
        end
    end

    // One-hot form of the winner, used for both ready and grant.
    always_comb begin
        win_oh_d            = '0;
        win_oh_d[win_idx_d] = 1'b1;
    end

    // Ready only in IDLE and only for the winner; forced low while in reset.
    always_comb begin
        req_ready = '0;
        if (!RESET && (state_q == IDLE) && win_vld_d) begin
            req_ready = win_oh_d;
        end
    end

    // Arbiter FSM with registered strobe, data, grant and error outputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            lock_q    <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            grant_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A valid winner always sees ready, so this is the transfer edge.
                    if (win_vld_d) begin
                        tx_data_q <= req_data[{win_idx_d, 3'b000} +: 8];
                        last_q    <= req_last[win_idx_d];
                        owner_q   <= win_idx_d;
                        grant_q   <= win_oh_d;
                        tx_en_q   <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        lock_q  <= 1'b0;
                        grant_q <= '0;
                        rr_q    <= next_idx(owner_q);
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= IDLE;
                        if (last_q) begin
                            lock_q  <= 1'b0;
                            grant_q <= '0;
                            rr_q    <= next_idx(owner_q);
                        end else begin
                            lock_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. A transaction-level model (round-robin
//   pointer, lock owner, packet completion on transmitter busy-fall, timeout
//   deadline) is compared against the DUT on every falling edge; directed
//   scenarios pin the model with hand-computed owner/data sequences.
module tb_uart_tx_arbiter;

    logic        CLOCK;
    logic        RESET;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        tx_busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [2:0]  grant;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transmitter model controls
    logic alive;
    int   bdelay;
    int   blen;

    // Observed tx_en log
    int         n_en = 0;
    int         en_owner[$];
    logic [7:0] en_data[$];

    uart_tx_arbiter #(.NREQ(3), .BUSY_TIMEOUT(16)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_busy     (tx_busy),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh2idx(input logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    // 8N1 transmitter stand-in: busy for blen cycles, bdelay after tx_en.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge CLOCK); #1;
            if (tx_en && alive) begin
                repeat (bdelay) begin @(posedge CLOCK); #1; end
                tx_busy = 1'b1;
                repeat (blen) begin @(posedge CLOCK); #1; end
                tx_busy = 1'b0;
            end
        end
    end

    // Transaction-level model and per-cycle compare.
    int         m_rr, m_owner, m_due, last_en;
    logic       m_lock, m_inflight, m_seen, m_pend, m_last, m_err;
    logic [7:0] m_byte;

    initial begin
        logic       pend;
        logic [2:0] exp_grant, exp_ready;
        int         idx;
        m_rr = 0; m_owner = 0; m_due = -1; last_en = -100;
        m_lock = 0; m_inflight = 0; m_seen = 0; m_pend = 0; m_last = 0; m_err = 0;
        m_byte = 8'h00;
        forever begin
            @(negedge CLOCK);
            cyc++;
            if (RESET) begin
                chk("rst_tx_en", 32'(tx_en), 0);
                chk("rst_tx_data", 32'(tx_data), 0);
                chk("rst_grant", 32'(grant), 0);
                chk("rst_ready", 32'(req_ready), 0);
                chk("rst_err", 32'(err_timeout), 0);
                m_rr = 0; m_due = -1; last_en = -100;
                m_lock = 0; m_inflight = 0; m_seen = 0; m_pend = 0; m_err = 0;
            end else begin
                pend   = m_pend;
                m_pend = 1'b0;
                // Timeout deadline reached: DUT is back in IDLE this cycle.
                if (m_due >= 0 && cyc == m_due) begin
                    m_inflight = 0;
                    m_lock     = 0;
                    m_rr       = (m_owner + 1) % 3;
                    m_err      = 1;
                    m_due      = -1;
                end
                chk("tx_en", 32'(tx_en), 32'(pend));
                if (tx_en) begin
                    n_en++;
                    en_owner.push_back(oh2idx(grant));
                    en_data.push_back(tx_data);
                    chk("tx_data", 32'(tx_data), 32'(m_byte));
                    chk("en_spacing", 32'(cyc - last_en >= 4), 1);
                    last_en = cyc;
                    if (!alive) m_due = cyc + 17;
                end
                chk("err_timeout", 32'(err_timeout), 32'(m_err));
                exp_grant = (m_inflight || m_lock) ? 3'(1 << m_owner) : 3'b000;
                chk("grant", 32'(grant), 32'(exp_grant));
                exp_ready = 3'b000;
                if (!m_inflight) begin
                    if (m_lock) begin
                        if (req_valid[m_owner]) exp_ready = 3'(1 << m_owner);
                    end else begin
                        for (int k = 2; k >= 0; k--) begin
                            idx = (m_rr + k) % 3;
                            if (req_valid[idx]) exp_ready = 3'(1 << idx);
                        end
                    end
                end
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                if (exp_ready != 3'b000) begin
                    m_owner    = oh2idx(exp_ready);
                    m_byte     = req_data[8*m_owner +: 8];
                    m_last     = req_last[m_owner];
                    m_inflight = 1;
                    m_seen     = 0;
                    m_pend     = 1;
                end else if (m_inflight && m_due < 0) begin
                    // Packet byte completes on the first idle cycle after busy.
                    if (tx_busy) begin
                        m_seen = 1;
                    end else if (m_seen) begin
                        m_inflight = 0;
                        if (m_last) begin
                            m_lock = 0;
                            m_rr   = (m_owner + 1) % 3;
                        end else begin
                            m_lock = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLOCK); #1; end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(1);
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic l);
        logic ok;
        ok = 1'b0;
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = b;
        req_last[i]        = l;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge CLOCK);
            if (req_ready[i]) ok = 1'b1;
            @(posedge CLOCK); #1;
        end
        req_valid[i] = 1'b0;
        chk("send_accept", 32'(ok), 1);
    endtask

    task automatic wait_en(input int n);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            tick(1);
            if (n_en >= n) ok = 1'b1;
        end
        chk("wait_tx_en", 32'(ok), 1);
    endtask

    initial begin
        int base;
        RESET     = 1'b1;
        req_valid = 3'b000;
        req_data  = 24'h0;
        req_last  = 3'b000;
        alive     = 1'b1;
        bdelay    = 0;
        blen      = 3;
        tick(2);
        chk("rst_grant_lit", 32'(grant), 0);
        RESET = 1'b0;
        tick(2);

        // Single byte from req0, busy for 10 cycles
        blen = 10;
        base = n_en;
        send(0, 8'h41, 1'b1);
        tick(20);
        chk("s1_pulses", 32'(n_en - base), 1);
        chk("s1_owner", 32'(en_owner[base]), 0);
        chk("s1_tx_data", 32'(tx_data), 32'h41);
        chk("s1_grant_end", 32'(grant), 0);
        // rr_ptr now 1: req1 beats req0
        base = n_en;
        req_data  = 24'h002211;
        req_last  = 3'b011;
        req_valid = 3'b011;
        wait_en(base + 1);
        req_valid = 3'b000;
        chk("s1_rr_owner", 32'(en_owner[base]), 1);
        tick(20);

        // Contention, all valid, single-byte packets
        do_reset();
        blen      = 3;
        base      = n_en;
        req_data  = 24'hC3B2A1;
        req_last  = 3'b111;
        req_valid = 3'b111;
        wait_en(base + 4);
        req_valid = 3'b000;
        tick(15);
        chk("s2_owner0", 32'(en_owner[base]),   0);
        chk("s2_owner1", 32'(en_owner[base+1]), 1);
        chk("s2_owner2", 32'(en_owner[base+2]), 2);
        chk("s2_owner3", 32'(en_owner[base+3]), 0);
        chk("s2_data2",  32'(en_data[base+2]),  32'hC3);

        // Packet lock: req0 three bytes while req1 valid throughout
        do_reset();
        bdelay         = 2;
        base           = n_en;
        req_data[15:8] = 8'h55;
        req_last[1]    = 1'b1;
        req_valid[1]   = 1'b1;
        send(0, 8'h10, 1'b0);
        send(0, 8'h11, 1'b0);
        send(0, 8'h12, 1'b1);
        wait_en(base + 4);
        req_valid[1] = 1'b0;
        tick(15);
        chk("s3_owner0", 32'(en_owner[base]),   0);
        chk("s3_owner1", 32'(en_owner[base+1]), 0);
        chk("s3_owner2", 32'(en_owner[base+2]), 0);
        chk("s3_owner3", 32'(en_owner[base+3]), 1);
        chk("s3_data1",  32'(en_data[base+1]),  32'h11);
        chk("s3_data3",  32'(en_data[base+3]),  32'h55);

        // Timeout: transmitter never goes busy
        do_reset();
        bdelay = 0;
        alive  = 1'b0;
        base   = n_en;
        send(2, 8'h77, 1'b1);
        tick(25);
        chk("s4_err", 32'(err_timeout), 1);
        chk("s4_grant", 32'(grant), 0);
        chk("s4_owner", 32'(en_owner[base]), 2);
        alive          = 1'b1;
        base           = n_en;
        req_data[15:8] = 8'h66;
        req_last[1]    = 1'b1;
        req_valid[1]   = 1'b1;
        send(0, 8'h88, 1'b1);
        wait_en(base + 2);
        req_valid[1] = 1'b0;
        tick(15);
        chk("s4_next_owner", 32'(en_owner[base]), 0);
        chk("s4_then_owner", 32'(en_owner[base+1]), 1);
        chk("s4_err_sticky", 32'(err_timeout), 1);

        // Reset pulsed while in WAIT_DONE
        blen = 10;
        base = n_en;
        send(1, 8'h99, 1'b1);
        tick(3);
        RESET = 1'b1;
        #1;
        chk("s5_tx_en", 32'(tx_en), 0);
        chk("s5_tx_data", 32'(tx_data), 0);
        chk("s5_grant", 32'(grant), 0);
        chk("s5_err", 32'(err_timeout), 0);
        chk("s5_ready", 32'(req_ready), 0);
        tick(2);
        RESET = 1'b0;
        tick(15);
        chk("s5_no_pulse", 32'(n_en - base), 1);
        req_data  = 24'hC3B2A1;
        req_last  = 3'b111;
        req_valid = 3'b111;
        wait_en(base + 2);
        req_valid = 3'b000;
        tick(15);
        chk("s5_first_owner", 32'(en_owner[base+1]), 0);

        // Locked owner goes idle; other requester must wait
        do_reset();
        blen = 3;
        base = n_en;
        send(1, 8'h61, 1'b0);
        tick(10);
        req_data[7:0] = 8'h62;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        tick(10);
        chk("s6_ready_held", 32'(req_ready), 0);
        chk("s6_grant_held", 32'(grant), 32'b010);
        chk("s6_pulses", 32'(n_en - base), 1);
        send(1, 8'h63, 1'b1);
        wait_en(base + 3);
        req_valid[0] = 1'b0;
        tick(15);
        chk("s6_owner1", 32'(en_owner[base+1]), 1);
        chk("s6_owner2", 32'(en_owner[base+2]), 0);
        chk("s6_data2",  32'(en_data[base+2]),  32'h62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
